// File: rtl/itcm_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : itcm_ctrl_if
// Description : Fetch and loader bus between a core/loader and itcm_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface itcm_ctrl_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32,
    parameter int PC_WIDTH   = 32
);
    logic                    cpu_en;
    logic                    rd_insn_en;
    logic [PC_WIDTH-1:0]     pc;
    logic [WORD_WIDTH-1:0]   insn;
    logic                    insn_valid;
    logic                    insn_err;
    logic                    ld_en;
    logic [ADDR_WIDTH-1:0]   ld_addr;
    logic [WORD_WIDTH-1:0]   ld_data;
    logic [WORD_WIDTH/8-1:0] ld_be;
    logic                    ld_ready;
    logic                    busy;

    modport master (
        output cpu_en, rd_insn_en, pc, ld_en, ld_addr, ld_data, ld_be,
        input  insn, insn_valid, insn_err, ld_ready, busy
    );

    modport slave (
        input  cpu_en, rd_insn_en, pc, ld_en, ld_addr, ld_data, ld_be,
        output insn, insn_valid, insn_err, ld_ready, busy
    );
endinterface
`default_nettype wire

// File: rtl/itcm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : itcm_ctrl
// Description : Instruction TCM with power-on clear, byte-masked loader
//               writes and a one-cycle registered fetch port.
// Revision    : 1.0 - initial release
// ============================================================================
module itcm_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 32,
    parameter int PC_WIDTH   = 32
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    itcm_ctrl_if.slave    bus
);
    localparam int              c_DEPTH    = 1 << ADDR_WIDTH;
    localparam int              c_BYTES    = WORD_WIDTH / 8;
    localparam logic [0:0]      c_ST_CLEAR = 1'b0;
    localparam logic [0:0]      c_ST_READY = 1'b1;
    localparam [ADDR_WIDTH-1:0] c_LAST_IDX = {ADDR_WIDTH{1'b1}};
    localparam [ADDR_WIDTH-1:0] c_CNT_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic [WORD_WIDTH-1:0] r_mem [0:c_DEPTH-1];
    logic [WORD_WIDTH-1:0] r_insn;
    logic                  r_insn_valid;
    logic                  r_insn_err;
    logic                  w_busy;
    logic                  w_ld_ready;
    logic                  w_fetch_acc;
    logic                  w_fetch_bad;
    logic [ADDR_WIDTH-1:0] w_fetch_idx;

    // State register and clear counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + c_CNT_ONE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CLEAR: if (r_clr_cnt == c_LAST_IDX) w_state_nxt = c_ST_READY;
            default:    w_state_nxt = c_ST_READY;
        endcase
    end

    always_comb begin
        w_busy     = 1'b0;
        w_ld_ready = 1'b0;
        case (r_state)
            c_ST_CLEAR: w_busy     = 1'b1;
            default:    w_ld_ready = 1'b1;
        endcase
    end

    // Clear owns the write port until READY; loader writes only then
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (r_state == c_ST_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (bus.ld_en) begin
                for (int b = 0; b < c_BYTES; b++) begin
                    if (bus.ld_be[b]) begin
                        r_mem[bus.ld_addr][b*8 +: 8] <= bus.ld_data[b*8 +: 8];
                    end
                end
            end
        end
    end

    assign w_fetch_acc = w_ld_ready && bus.cpu_en && bus.rd_insn_en;
    assign w_fetch_idx = bus.pc[ADDR_WIDTH+1:2];
    assign w_fetch_bad = (bus.pc[1:0] != 2'b00) || (|bus.pc[PC_WIDTH-1:ADDR_WIDTH+2]);

    // Non-blocking memory writes make a same-edge fetch see the old word
    always_ff @(posedge clk) begin
        if (!rst_n || !w_fetch_acc) begin
            r_insn       <= '0;
            r_insn_valid <= 1'b0;
            r_insn_err   <= 1'b0;
        end else begin
            r_insn_valid <= 1'b1;
            r_insn_err   <= w_fetch_bad;
            r_insn       <= w_fetch_bad ? '0 : r_mem[w_fetch_idx];
        end
    end

    assign bus.insn       = r_insn;
    assign bus.insn_valid = r_insn_valid;
    assign bus.insn_err   = r_insn_err;
    assign bus.busy       = w_busy;
    assign bus.ld_ready   = w_ld_ready;
endmodule
`default_nettype wire

// File: tb/tb_itcm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_itcm_ctrl
// Description : Scoreboard bench for itcm_ctrl with a 16-word memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itcm_ctrl;
    localparam int c_AW = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [32:0] exp_q[$];

    itcm_ctrl_if #(.ADDR_WIDTH(c_AW)) bus ();

    itcm_ctrl #(.ADDR_WIDTH(c_AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expected {err, insn} per presented result
    always @(posedge clk) begin
        logic [32:0] e;
        #1;
        if (bus.insn_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_fetch: got insn 0x%08h err %0b expected no result",
                         bus.insn, bus.insn_err);
            end else begin
                e = exp_q.pop_front();
                if (bus.insn !== e[31:0] || bus.insn_err !== e[32]) begin
                    errors++;
                    $display("FAIL fetch_result: got insn 0x%08h err %0b expected insn 0x%08h err %0b",
                             bus.insn, bus.insn_err, e[31:0], e[32]);
                end
            end
        end else begin
            checks++;
            if (bus.insn !== 32'h0 || bus.insn_err !== 1'b0) begin
                errors++;
                $display("FAIL idle_outputs: got insn 0x%08h err %0b expected 0 0",
                         bus.insn, bus.insn_err);
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ee);
        bus.cpu_en     = 1'b1;
        bus.rd_insn_en = 1'b1;
        bus.pc         = a;
        exp_q.push_back({ee, ei});
        @(negedge clk);
        bus.rd_insn_en = 1'b0;
    endtask

    task automatic load(input logic [3:0] idx, input logic [31:0] d, input logic [3:0] be);
        bus.ld_en   = 1'b1;
        bus.ld_addr = idx;
        bus.ld_data = d;
        bus.ld_be   = be;
        @(negedge clk);
        bus.ld_en = 1'b0;
    endtask

    // Counts edges from release until busy drops; ld_ready must rise with it
    task automatic measure_clear(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.busy === 1'b1 && n < 100);
        check({name, "_busy_cycles"}, n, 16);
        check({name, "_ld_ready"}, {31'b0, bus.ld_ready}, 32'h1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        errors = 0;
        checks = 0;
        rst_n          = 1'b0;
        bus.cpu_en     = 1'b1;
        bus.rd_insn_en = 1'b1;
        bus.pc         = 32'h0;
        bus.ld_en      = 1'b0;
        bus.ld_addr    = '0;
        bus.ld_data    = '0;
        bus.ld_be      = '0;

        repeat (3) @(negedge clk);
        check("rst_busy",     {31'b0, bus.busy},       32'h1);
        check("rst_ld_ready", {31'b0, bus.ld_ready},   32'h0);
        check("rst_valid",    {31'b0, bus.insn_valid}, 32'h0);
        check("rst_err",      {31'b0, bus.insn_err},   32'h0);
        check("rst_insn",     bus.insn,                32'h0);

        // Fetch request held through CLEAR must be ignored
        rst_n = 1'b1;
        measure_clear("clear1");
        bus.rd_insn_en = 1'b0;

        for (int i = 0; i < 16; i++) fetch(i * 4, 32'h0, 1'b0);

        load(4'd2, 32'h0000_0013, 4'hF);
        load(4'd3, 32'hDEAD_BEEF, 4'hF);
        bus.cpu_en = 1'b1; bus.rd_insn_en = 1'b1;
        bus.pc = 32'h8; exp_q.push_back({1'b0, 32'h0000_0013});
        @(negedge clk);
        bus.pc = 32'hC; exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        @(negedge clk);
        bus.rd_insn_en = 1'b0;

        fetch(32'h6,  32'h0, 1'b1);
        fetch(32'h40, 32'h0, 1'b1);
        fetch(32'h8000_0000, 32'h0, 1'b1);

        load(4'd7, 32'h1122_3344, 4'hF);
        load(4'd7, 32'hAABB_CCDD, 4'b0101);
        fetch(32'h1C, 32'h11BB_33DD, 1'b0);
        load(4'd7, 32'hFFFF_FFFF, 4'h0);
        fetch(32'h1C, 32'h11BB_33DD, 1'b0);

        // Same-edge load and fetch to index 5
        bus.ld_en = 1'b1; bus.ld_addr = 4'd5; bus.ld_data = 32'hCAFE_F00D; bus.ld_be = 4'hF;
        fetch(32'h14, 32'h0, 1'b0);
        bus.ld_en = 1'b0;
        fetch(32'h14, 32'hCAFE_F00D, 1'b0);

        // cpu_en low blocks fetches but not loads
        bus.cpu_en = 1'b0; bus.rd_insn_en = 1'b1; bus.pc = 32'h20;
        load(4'd8, 32'h0000_0055, 4'hF);
        check("cpu_en0_valid", {31'b0, bus.insn_valid}, 32'h0);
        @(negedge clk);
        check("cpu_en0_valid2", {31'b0, bus.insn_valid}, 32'h0);
        bus.rd_insn_en = 1'b0;
        fetch(32'h20, 32'h0000_0055, 1'b0);

        // Reset in READY with a fetch at the same edge drops the result
        bus.cpu_en = 1'b1; bus.rd_insn_en = 1'b1; bus.pc = 32'h1C;
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready_busy", {31'b0, bus.busy}, 32'h1);
        rst_n = 1'b1;
        bus.rd_insn_en = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        measure_clear("clear2");

        fetch(32'h1C, 32'h0, 1'b0);
        fetch(32'h8,  32'h0, 1'b0);
        fetch(32'h14, 32'h0, 1'b0);
        repeat (2) @(negedge clk);

        check("scoreboard_drained", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
